// File: rtl/xcorr_pkg.sv
// Shared types and sizing for the cross-correlation peak finder.
// Holds the channel/lag geometry, the FSM state encoding and the lag-index type.
package xcorr_pkg;

    localparam int unsigned NUM_XCORRS     = 6;
    localparam int unsigned MAX_LAGS       = 11;
    localparam int unsigned CORR_WIDTH     = 24;
    localparam int unsigned NUM_LAGS       = 2 * MAX_LAGS + 1;
    localparam int unsigned BITS_PER_XCORR = $clog2(2 * MAX_LAGS + 1);
    localparam int unsigned LAGS_WIDTH     = NUM_XCORRS * BITS_PER_XCORR;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    typedef logic [BITS_PER_XCORR-1:0]    lag_idx_t;
    typedef logic signed [CORR_WIDTH-1:0] corr_t;

    localparam lag_idx_t LAST_LAG = lag_idx_t'(NUM_LAGS - 1);

endpackage

// File: rtl/xcorr_peak_finder_if.sv
// Stream/result bundle for xcorr_peak_finder.
//   corrIn/corrValid/corrStart : correlator sample stream (master -> slave)
//   lagsOut/lagsValid          : packed per-channel peak indices and update pulse
//   frameAbort                 : pulse when a partial frame is discarded
//   debugData/debugDataValid   : optional debug word and strobe
// master = upstream/consumer side, slave = the peak finder.
interface xcorr_peak_finder_if;
    import xcorr_pkg::*;

    logic [NUM_XCORRS*CORR_WIDTH-1:0] corrIn;
    logic                             corrValid;
    logic                             corrStart;
    logic [LAGS_WIDTH-1:0]            lagsOut;
    logic                             lagsValid;
    logic                             frameAbort;
    logic [31:0]                      debugData;
    logic                             debugDataValid;

    modport master (
        output corrIn, corrValid, corrStart,
        input  lagsOut, lagsValid, frameAbort, debugData, debugDataValid
    );

    modport slave (
        input  corrIn, corrValid, corrStart,
        output lagsOut, lagsValid, frameAbort, debugData, debugDataValid
    );

endinterface

// File: rtl/xcorr_peak_tracker.sv
// Running signed maximum and its lag index for one correlator channel.
//   clk, reset : clock, async active-high reset
//   clear      : zero the running max/index
//   load       : start a frame: sample becomes the max at index 0
//   enable     : compare sample (at lag lagCnt) against the running max
//   sample     : signed correlation sample
//   lagCnt     : lag index of sample when enable is high
//   maxVal     : running maximum
//   maxIdx     : lag index of running maximum (earliest on ties)
module xcorr_peak_tracker
    import xcorr_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     clear,
    input  logic     load,
    input  logic     enable,
    input  corr_t    sample,
    input  lag_idx_t lagCnt,
    output corr_t    maxVal,
    output lag_idx_t maxIdx
);

    corr_t    max_val_q, max_val_d;
    lag_idx_t max_idx_q, max_idx_d;

    always_comb begin
        max_val_d = max_val_q;
        max_idx_d = max_idx_q;
        if (load) begin
            max_val_d = sample;
            max_idx_d = '0;
        end else if (clear) begin
            max_val_d = '0;
            max_idx_d = '0;
        end else if (enable && (sample > max_val_q)) begin
            // strictly greater: a tie keeps the earlier lag
            max_val_d = sample;
            max_idx_d = lagCnt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            max_val_q <= '0;
            max_idx_q <= '0;
        end else begin
            max_val_q <= max_val_d;
            max_idx_q <= max_idx_d;
        end
    end

    assign maxVal = max_val_q;
    assign maxIdx = max_idx_q;

endmodule

// File: rtl/xcorr_peak_finder.sv
// Finds, per correlator channel, the lag index of the maximum correlation
// sample in a 23-sample frame and publishes all indices as one packed word.
//   clk   : system clock
//   reset : asynchronous, active-high
//   io    : xcorr_peak_finder_if.slave
//           in : corrIn, corrValid, corrStart (start qualified by valid)
//           out: lagsOut (5 bits/channel), lagsValid, frameAbort,
//                debugData, debugDataValid
// Optional feature macro: XCORR_PEAK_DEBUG_EN
//   defined  : debugData = {completed frame count[7:0], channel 0 peak value},
//              strobed with lagsValid
//   undefined: debug outputs tied to zero
module xcorr_peak_finder
    import xcorr_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    xcorr_peak_finder_if.slave  io
);

    state_t                state_q, state_d;
    lag_idx_t              lag_cnt_q, lag_cnt_d;
    logic [LAGS_WIDTH-1:0] lags_out_q, lags_out_d;
    logic                  lags_valid_q, lags_valid_d;
    logic                  frame_abort_q, frame_abort_d;

    logic                  trk_clear, trk_load, trk_enable;
    lag_idx_t              next_lag;
    logic                  start;
    logic [LAGS_WIDTH-1:0] packed_idx;

    corr_t    max_val [NUM_XCORRS];
    lag_idx_t max_idx [NUM_XCORRS];
    corr_t    unused_max_val [NUM_XCORRS];

    // only channel 0's peak value is observed, and only on the debug word
    assign unused_max_val = max_val;

    assign start    = io.corrValid && io.corrStart;
    // index of the sample currently on corrIn while scanning
    assign next_lag = lag_cnt_q + lag_idx_t'(1);

    for (genvar g = 0; g < NUM_XCORRS; g++) begin : g_trk
        xcorr_peak_tracker u_trk (
            .clk    (clk),
            .reset  (reset),
            .clear  (trk_clear),
            .load   (trk_load),
            .enable (trk_enable),
            .sample (io.corrIn[CORR_WIDTH*g +: CORR_WIDTH]),
            .lagCnt (next_lag),
            .maxVal (max_val[g]),
            .maxIdx (max_idx[g])
        );
    end

    always_comb begin
        packed_idx = '0;
        for (int unsigned i = 0; i < NUM_XCORRS; i++) begin
            packed_idx[BITS_PER_XCORR*i +: BITS_PER_XCORR] = max_idx[i];
        end
    end

    always_comb begin
        state_d       = state_q;
        lag_cnt_d     = lag_cnt_q;
        lags_out_d    = lags_out_q;
        lags_valid_d  = 1'b0;
        frame_abort_d = 1'b0;
        trk_clear     = 1'b0;
        trk_load      = 1'b0;
        trk_enable    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SCAN;
                    lag_cnt_d = '0;
                    trk_load  = 1'b1;
                end
            end
            SCAN: begin
                if (start) begin
                    // restart: the new start sample becomes index 0
                    frame_abort_d = 1'b1;
                    lag_cnt_d     = '0;
                    trk_load      = 1'b1;
                end else if (io.corrValid) begin
                    trk_enable = 1'b1;
                    lag_cnt_d  = next_lag;
                    if (next_lag == LAST_LAG) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // trackers are read and cleared on the same edge
                lags_out_d   = packed_idx;
                lags_valid_d = 1'b1;
                trk_clear    = 1'b1;
                lag_cnt_d    = '0;
                state_d      = IDLE;
                if (start) begin
                    frame_abort_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            lag_cnt_q     <= '0;
            lags_out_q    <= '0;
            lags_valid_q  <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            lag_cnt_q     <= lag_cnt_d;
            lags_out_q    <= lags_out_d;
            lags_valid_q  <= lags_valid_d;
            frame_abort_q <= frame_abort_d;
        end
    end

    assign io.lagsOut    = lags_out_q;
    assign io.lagsValid  = lags_valid_q;
    assign io.frameAbort = frame_abort_q;

`ifdef XCORR_PEAK_DEBUG_EN
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [31:0] debug_data_q, debug_data_d;
    logic        debug_valid_q, debug_valid_d;

    always_comb begin
        frame_cnt_d   = frame_cnt_q;
        debug_data_d  = debug_data_q;
        debug_valid_d = 1'b0;
        if (state_q == DONE) begin
            // count includes the frame being reported
            frame_cnt_d   = frame_cnt_q + 8'd1;
            debug_data_d  = {frame_cnt_d, max_val[0]};
            debug_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt_q   <= '0;
            debug_data_q  <= '0;
            debug_valid_q <= 1'b0;
        end else begin
            frame_cnt_q   <= frame_cnt_d;
            debug_data_q  <= debug_data_d;
            debug_valid_q <= debug_valid_d;
        end
    end

    assign io.debugData      = debug_data_q;
    assign io.debugDataValid = debug_valid_q;
`else
    assign io.debugData      = '0;
    assign io.debugDataValid = 1'b0;
`endif

endmodule
